reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL have the following parameters:
- pXlen, default cXLEN (32): data width.
- pNumRegs, default 32: architectural register count, a power of two.
- pNumRdPorts, default 2: number of read ports, 1..4.

REQ-002 The block SHALL have the following ports, clock and reset first:
- iClk, input, 1: single clock, rising edge.
- iRst, input, 1: reset; asynchronous, active-high.
- iRdEn, input, pNumRdPorts: per-port read enable.
- iRdAddr, input, pNumRdPorts x log2(pNumRegs): per-port source address.
- oRdData, output, pNumRdPorts x pXlen: per-port registered read data.
- iIssueValid, input, 1: an instruction claims destination iIssueRd.
- iIssueRd, input, log2(pNumRegs): destination being claimed.
- iWbValid, input, 1: writeback strobe.
- iWbAddr, input, log2(pNumRegs): writeback address.
- iWbData, input, pXlen: writeback data.
- iFlush, input, 1: discard all outstanding claims.
- oStall, output, 1: hazard; issue/read must be held.
- oPendingCnt, output, log2(pNumRegs)+1: number of pending registers.

Function
REQ-003 Register 0 SHALL read as zero, ignore writes, and never become pending.
REQ-004 Read latency SHALL be exactly 1 cycle: oRdData[p] updates at the edge after iRdEn[p]=1 and holds its value while iRdEn[p]=0.
REQ-005 A read and a writeback to the same nonzero address in the same cycle SHALL return iWbData (write-first bypass).
REQ-006 The writeback SHALL update the array at the clock edge when iWbValid=1 and iWbAddr!=0.
REQ-007 The scoreboard SHALL hold one pending bit per register. A bit is set at the edge when iIssueValid=1, oStall=0, iFlush=0 and iIssueRd!=0. It is cleared at the edge when iWbValid=1 for that address.
REQ-008 Issue and writeback to the same register in the same cycle SHALL leave the bit set, because the newer claim wins.
REQ-009 oStall SHALL be combinational and asserted when either condition holds:
- RAW: some port p has iRdEn[p]=1 and pending[iRdAddr[p]]=1, unless iWbValid=1 and iWbAddr=iRdAddr[p].
- WAW: iIssueValid=1 and pending[iIssueRd]=1, unless the same-cycle writeback clears that bit.
REQ-010 While oStall=1, the issue SHALL be ignored. Reads still update oRdData; the consumer discards the stalled result.
REQ-011 iFlush=1 SHALL clear all pending bits at the next edge, take priority over a same-cycle issue, and leave array contents and writeback behaviour unaffected.
REQ-012 oPendingCnt SHALL equal the registered popcount of the pending bits, ranging 0..pNumRegs-1.

Reset
REQ-013 While iRst=1, regardless of clock, the block SHALL drive all array entries, all pending bits, oRdData and oPendingCnt to 0.
REQ-014 Reset asserted mid-operation SHALL drop all outstanding claims without completing them. The first edge after deassertion behaves as from power-up.

Structure
REQ-015 cXLEN, cRegAddrW and a tRegControl-compatible writeback struct (valid, addr, data) SHALL live in corePckg.
REQ-016 The scoreboard (REQ-007..REQ-012) SHALL be a sub-module named rf_scoreboard. reg_file_sb SHALL contain the storage array, the bypass logic and the rf_scoreboard instance.

Verification
REQ-017 The bench SHALL cover the following directed scenarios:
- Reset, then read x5 on both ports: 0x0 after 1 cycle. Write x0=0xDEADBEEF, then read x0: 0x0.
- Write x7=0x12345678 while port 1 reads x7 in the same cycle: oRdData[1]=0x12345678 at the next edge.
- Issue rd=x3, next cycle read x3: oStall=1 and oPendingCnt=1. Writeback x3=0xA5A5 in the same cycle as the read: oStall=0 and data is 0xA5A5.
- With x4 pending, issue rd=x4 again (WAW): oStall=1 and the count stays 1. Issue x4 and writeback x4 together: the bit stays set.
- Issue x1, x2 and x9 (count=3), then assert iFlush together with an issue of x10: count=0 next cycle and x10 not pending.
- Assert iRst asynchronously between edges with 2 pending: oPendingCnt=0 and oRdData=0 immediately.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// Shared core constants and the writeback bundle used by the register file.
package corePckg;

   localparam int unsigned cXLEN     = 32;
   localparam int unsigned cRegAddrW = 5;

   // Writeback bundle: one destination update per cycle
   typedef struct packed {
      logic                 valid;
      logic [cRegAddrW-1:0] addr;
      logic [cXLEN-1:0]     data;
   } tRegControl;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-destination scoreboard: per-register busy bits, RAW/WAW stall and a
// registered count of outstanding claims.
module rf_scoreboard
   import corePckg::*;
#(
   parameter int unsigned pNumRegs    = 32,
   parameter int unsigned pNumRdPorts = 2
) (
   input  logic                                         iClk,
   input  logic                                         iRst,
   input  logic [pNumRdPorts-1:0]                       iRdEn,
   input  logic [pNumRdPorts-1:0][$clog2(pNumRegs)-1:0] iRdAddr,
   input  logic                                         iIssueValid,
   input  logic [$clog2(pNumRegs)-1:0]                  iIssueRd,
   input  logic                                         iWbValid,
   input  logic [$clog2(pNumRegs)-1:0]                  iWbAddr,
   input  logic                                         iFlush,
   output logic                                         oStall,
   output logic [$clog2(pNumRegs):0]                    oPendingCnt
);

   localparam int unsigned AW = $clog2(pNumRegs);
   localparam int unsigned CW = AW + 1;

   logic [pNumRegs-1:0] r_pending;
   logic [pNumRegs-1:0] w_pending_nxt;
   logic [CW-1:0]       w_cnt_nxt;
   logic                w_raw;
   logic                w_waw;

   // Hazard detection; a same-cycle writeback to the register resolves it
   always_comb begin
      w_raw = 1'b0;
      for (int p = 0; p < int'(pNumRdPorts); p++) begin
         if (iRdEn[p] && r_pending[iRdAddr[p]] &&
             !(iWbValid && (iWbAddr == iRdAddr[p])))
            w_raw = 1'b1;
      end
      w_waw  = iIssueValid && r_pending[iIssueRd] &&
               !(iWbValid && (iWbAddr == iIssueRd));
      oStall = w_raw || w_waw;
   end

   // Clear on writeback first, then set on issue so the newer claim wins
   always_comb begin
      w_pending_nxt = r_pending;
      if (iFlush) begin
         w_pending_nxt = '0;
      end else begin
         if (iWbValid)
            w_pending_nxt[iWbAddr] = 1'b0;
         if (iIssueValid && !oStall && (iIssueRd != '0))
            w_pending_nxt[iIssueRd] = 1'b1;
      end
      w_pending_nxt[0] = 1'b0;
   end

   always_comb begin
      w_cnt_nxt = '0;
      for (int i = 0; i < int'(pNumRegs); i++)
         w_cnt_nxt = w_cnt_nxt + CW'(w_pending_nxt[i]);
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         r_pending   <= '0;
         oPendingCnt <= '0;
      end else begin
         r_pending   <= w_pending_nxt;
         oPendingCnt <= w_cnt_nxt;
      end
   end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with write-first bypass and an attached
// destination scoreboard for hazard stalls.
module reg_file_sb
   import corePckg::*;
#(
   parameter int unsigned pXlen       = cXLEN,
   parameter int unsigned pNumRegs    = 32,
   parameter int unsigned pNumRdPorts = 2
) (
   input  logic                                         iClk,
   input  logic                                         iRst,
   input  logic [pNumRdPorts-1:0]                       iRdEn,
   input  logic [pNumRdPorts-1:0][$clog2(pNumRegs)-1:0] iRdAddr,
   output logic [pNumRdPorts-1:0][pXlen-1:0]            oRdData,
   input  logic                                         iIssueValid,
   input  logic [$clog2(pNumRegs)-1:0]                  iIssueRd,
   input  logic                                         iWbValid,
   input  logic [$clog2(pNumRegs)-1:0]                  iWbAddr,
   input  logic [pXlen-1:0]                             iWbData,
   input  logic                                         iFlush,
   output logic                                         oStall,
   output logic [$clog2(pNumRegs):0]                    oPendingCnt
);

   logic [pXlen-1:0] r_mem [pNumRegs];
   logic             w_wr_en;

   assign w_wr_en = iWbValid && (iWbAddr != '0);

   // x0 is never written, so it stays at its reset value of zero
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         for (int i = 0; i < int'(pNumRegs); i++)
            r_mem[i] <= '0;
      end else if (w_wr_en) begin
         r_mem[iWbAddr] <= iWbData;
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         oRdData <= '0;
      end else begin
         for (int p = 0; p < int'(pNumRdPorts); p++) begin
            if (iRdEn[p]) begin
               if (iRdAddr[p] == '0)
                  oRdData[p] <= '0;
               else if (w_wr_en && (iWbAddr == iRdAddr[p]))
                  oRdData[p] <= iWbData;
               else
                  oRdData[p] <= r_mem[iRdAddr[p]];
            end
         end
      end
   end

   rf_scoreboard #(
      .pNumRegs    (pNumRegs),
      .pNumRdPorts (pNumRdPorts)
   ) u_scoreboard (
      .iClk        (iClk),
      .iRst        (iRst),
      .iRdEn       (iRdEn),
      .iRdAddr     (iRdAddr),
      .iIssueValid (iIssueValid),
      .iIssueRd    (iIssueRd),
      .iWbValid    (iWbValid),
      .iWbAddr     (iWbAddr),
      .iFlush      (iFlush),
      .oStall      (oStall),
      .oPendingCnt (oPendingCnt)
   );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed scenarios plus random traffic against an array-based reference model.
module tb_reg_file_sb;

   logic             iClk;
   logic             iRst;
   logic [1:0]       iRdEn;
   logic [1:0][4:0]  iRdAddr;
   logic [1:0][31:0] oRdData;
   logic             iIssueValid;
   logic [4:0]       iIssueRd;
   logic             iWbValid;
   logic [4:0]       iWbAddr;
   logic [31:0]      iWbData;
   logic             iFlush;
   logic             oStall;
   logic [5:0]       oPendingCnt;

   int errors = 0;
   int checks = 0;

   logic [31:0] m_mem  [32];
   bit          m_pend [32];
   logic [31:0] m_rd   [2];

   reg_file_sb dut (
      .iClk        (iClk),
      .iRst        (iRst),
      .iRdEn       (iRdEn),
      .iRdAddr     (iRdAddr),
      .oRdData     (oRdData),
      .iIssueValid (iIssueValid),
      .iIssueRd    (iIssueRd),
      .iWbValid    (iWbValid),
      .iWbAddr     (iWbAddr),
      .iWbData     (iWbData),
      .iFlush      (iFlush),
      .oStall      (oStall),
      .oPendingCnt (oPendingCnt)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      iRdEn = '0; iRdAddr = '0; iIssueValid = 0; iIssueRd = '0;
      iWbValid = 0; iWbAddr = '0; iWbData = '0; iFlush = 0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_pend[i] = 0; end
      m_rd[0] = '0; m_rd[1] = '0;
   endtask

   function automatic bit model_stall();
      bit s = 0;
      for (int p = 0; p < 2; p++)
         if (iRdEn[p] && m_pend[iRdAddr[p]] && !(iWbValid && iWbAddr == iRdAddr[p])) s = 1;
      if (iIssueValid && m_pend[iIssueRd] && !(iWbValid && iWbAddr == iIssueRd)) s = 1;
      return s;
   endfunction

   function automatic int model_count();
      int c = 0;
      for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
      return c;
   endfunction

   // One clock: check stall before the edge, advance the model, check outputs after
   task automatic cyc();
      bit s;
      #1;
      s = model_stall();
      check("stall", 32'(oStall), 32'(s));
      @(posedge iClk);
      for (int p = 0; p < 2; p++)
         if (iRdEn[p])
            m_rd[p] = (iRdAddr[p] == 0) ? 32'h0 :
                      (iWbValid && iWbAddr == iRdAddr[p]) ? iWbData : m_mem[iRdAddr[p]];
      if (iWbValid && iWbAddr != 0) m_mem[iWbAddr] = iWbData;
      if (iFlush) begin
         for (int i = 0; i < 32; i++) m_pend[i] = 0;
      end else begin
         if (iWbValid) m_pend[iWbAddr] = 0;
         if (iIssueValid && !s && iIssueRd != 0) m_pend[iIssueRd] = 1;
      end
      #1;
      check("rd0", oRdData[0], m_rd[0]);
      check("rd1", oRdData[1], m_rd[1]);
      check("cnt", 32'(oPendingCnt), 32'(model_count()));
   endtask

   initial begin
      idle();
      model_reset();
      iRst = 0;
      #2 iRst = 1;
      #2;
      check("rst_cnt", 32'(oPendingCnt), 32'h0);
      check("rst_rd0", oRdData[0], 32'h0);
      @(negedge iClk); @(negedge iClk);
      iRst = 0;

      // x5 reads zero on both ports; x0 ignores writes
      iRdEn = 2'b11; iRdAddr[0] = 5'd5; iRdAddr[1] = 5'd5;
      cyc();
      check("x5_p0", oRdData[0], 32'h0);
      check("x5_p1", oRdData[1], 32'h0);
      idle(); iWbValid = 1; iWbAddr = 5'd0; iWbData = 32'hDEADBEEF;
      cyc();
      idle(); iRdEn = 2'b01; iRdAddr[0] = 5'd0;
      cyc();
      check("x0_zero", oRdData[0], 32'h0);

      // write-first bypass
      idle(); iWbValid = 1; iWbAddr = 5'd7; iWbData = 32'h12345678;
      iRdEn = 2'b10; iRdAddr[1] = 5'd7;
      cyc();
      check("bypass_x7", oRdData[1], 32'h12345678);

      // RAW stall, resolved by same-cycle writeback
      idle(); iIssueValid = 1; iIssueRd = 5'd3;
      cyc();
      idle(); iRdEn = 2'b01; iRdAddr[0] = 5'd3;
      #1;
      check("raw_stall", 32'(oStall), 32'h1);
      check("raw_cnt", 32'(oPendingCnt), 32'h1);
      iWbValid = 1; iWbAddr = 5'd3; iWbData = 32'h0000A5A5;
      #1;
      check("raw_wb_nostall", 32'(oStall), 32'h0);
      cyc();
      check("raw_wb_data", oRdData[0], 32'h0000A5A5);

      // WAW stall, then issue+writeback on the same register
      idle(); iIssueValid = 1; iIssueRd = 5'd4;
      cyc();
      #1;
      check("waw_stall", 32'(oStall), 32'h1);
      cyc();
      check("waw_cnt", 32'(oPendingCnt), 32'h1);
      iWbValid = 1; iWbAddr = 5'd4; iWbData = 32'h44;
      cyc();
      check("iss_wb_cnt", 32'(oPendingCnt), 32'h1);
      idle(); iRdEn = 2'b10; iRdAddr[1] = 5'd4;
      #1;
      check("iss_wb_pend", 32'(oStall), 32'h1);
      idle(); iWbValid = 1; iWbAddr = 5'd4; iWbData = 32'h55;
      cyc();

      // flush beats a same-cycle issue
      idle(); iIssueValid = 1;
      iIssueRd = 5'd1; cyc();
      iIssueRd = 5'd2; cyc();
      iIssueRd = 5'd9; cyc();
      check("three_cnt", 32'(oPendingCnt), 32'h3);
      iIssueRd = 5'd10; iFlush = 1;
      cyc();
      check("flush_cnt", 32'(oPendingCnt), 32'h0);
      idle(); iRdEn = 2'b01; iRdAddr[0] = 5'd10;
      #1;
      check("flush_x10", 32'(oStall), 32'h0);
      cyc();

      // asynchronous reset mid-operation
      idle(); iIssueValid = 1; iIssueRd = 5'd5; iRdEn = 2'b11;
      iRdAddr[0] = 5'd7; iRdAddr[1] = 5'd7;
      cyc();
      idle(); iIssueValid = 1; iIssueRd = 5'd6;
      cyc();
      check("pre_rst_cnt", 32'(oPendingCnt), 32'h2);
      idle();
      #3 iRst = 1;
      #1;
      check("async_cnt", 32'(oPendingCnt), 32'h0);
      check("async_rd0", oRdData[0], 32'h0);
      check("async_rd1", oRdData[1], 32'h0);
      model_reset();
      @(posedge iClk); @(negedge iClk);
      iRst = 0;

      // random traffic on a small address range to provoke hazards
      for (int n = 0; n < 600; n++) begin
         iRdEn       = 2'($urandom);
         iRdAddr[0]  = 5'($urandom_range(0, 7));
         iRdAddr[1]  = 5'($urandom_range(0, 7));
         iIssueValid = ($urandom_range(0, 2) == 0);
         iIssueRd    = 5'($urandom_range(0, 7));
         iWbValid    = ($urandom_range(0, 1) == 0);
         iWbAddr     = 5'($urandom_range(0, 7));
         iWbData     = $urandom;
         iFlush      = ($urandom_range(0, 31) == 0);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
